alu_mdu: RTL

- Next-generation execute-stage ALU: WIDTH-parametrised combinational ALU plus an iterative multiply/divide unit (MDU) that owns HI/LO registers.
- The combinational path produces r/z in the same cycle.
- The MDU runs multi-cycle and raises busy so the pipeline hazard logic can stall mfhi/mflo and new mult/div until done.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mdu_seq.sv | 115 +++++++++++
 rtl/alu_mdu.sv | 77 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and its multiply/divide unit.
package alu_pkg;

    // aluc[1:0] function groups; aluc[2] selects the alternate op, aluc[3] only affects right shifts.
    localparam logic [1:0] ALU_ADDSUB = 2'b00;
    localparam logic [1:0] ALU_ANDOR  = 2'b01;
    localparam logic [1:0] ALU_XORLUI = 2'b10;
    localparam logic [1:0] ALU_SHIFT  = 2'b11;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } md_state_t;

endpackage

// File: rtl/alu_mdu_seq.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, owns HI/LO.
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    md_state_t          state, state_nxt;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd_b;
    logic               op_div, neg_q, neg_r;
    logic               start_ok, in_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // A start in the done cycle is dropped: the pipeline re-issues it once done clears.
    assign start_ok  = (state == IDLE) && md_start && !done;
    assign in_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign a_neg     = in_signed && a[WIDTH-1];
    assign b_neg     = in_signed && b[WIDTH-1];
    assign mag_a     = a_neg ? -a : a;
    assign mag_b     = b_neg ? -b : b;
    assign busy      = (state != IDLE);

    // acc_lo holds the multiplier (mult) or the dividend feeding the quotient (div).
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_b};

    assign prod_fix  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_fix   = (opnd_b == '0) ? '1 : (neg_q ? -acc_lo : acc_lo);
    assign rem_fix   = neg_r ? -acc_hi : acc_hi;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no branch leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (count == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: datapath registers carry no reset; every start reloads them before use.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            count  <= CW'(WIDTH);
            op_div <= (md_op == MD_DIV) || (md_op == MD_DIVU);
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            acc_hi <= '0;
            acc_lo <= mag_a;
            opnd_b <= mag_b;
        end else if (state == RUN) begin
            count <= count - CW'(1);
            if (op_div) begin
                if (!div_trial[WIDTH]) begin
                    acc_hi <= div_trial[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                if (op_div) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end else if (state == IDLE && !md_start) begin
                if (mthi) hi <= a;
                if (mtlo) lo <= a;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU (combinational r/z) plus iterative MDU; define ALU_OVF_EN to add the ov output.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic [WIDTH-1:0] r,
    output logic             z,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef ALU_OVF_EN
    ,
    output logic             ov
`endif
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = a[SHW-1:0];

    always_comb begin
        r = '0;
        case (aluc[1:0])
            ALU_ADDSUB: r = aluc[2] ? a - b : a + b;
            ALU_ANDOR:  r = aluc[2] ? a | b : a & b;
            ALU_XORLUI: r = aluc[2] ? {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}} : a ^ b;
            ALU_SHIFT: begin
                if (!aluc[2])    r = b << shamt;
                else if (aluc[3]) r = $signed(b) >>> shamt;
                else             r = b >> shamt;
            end
            default:    r = '0;
        endcase
    end

    assign z = ~|r;

`ifdef ALU_OVF_EN
    // Overflow: operands that should share a sign (after negating b for sub) disagree with r.
    always_comb begin
        ov = 1'b0;
        if (aluc[1:0] == ALU_ADDSUB) begin
            if (aluc[2]) ov = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            else         ov = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        end
    end
`endif

    alu_mdu_seq #(
        .WIDTH(WIDTH)
    ) u_seq (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .md_start(md_start),
        .md_op   (md_op),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

endmodule
